// File: rtl/tdc_meas_accum.sv
// TDC measurement accumulator: gathers 2^LOG2_S Hamming-weight samples per
// measurement and reports sum/min/max/mean/count, aborting on a valid-gap timeout.
module tdc_meas_accum #(
    parameter int  HW_W   = 7,
    parameter int  LOG2_S = 4,
    parameter int  TO_CYC = 255,
    localparam int SUM_W  = HW_W + LOG2_S,
    localparam int CNT_W  = LOG2_S + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_start,
    input  logic [HW_W-1:0]   i_hw_in,
    input  logic              i_val_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [SUM_W-1:0]  o_sum_out,
    output logic [HW_W-1:0]   o_min_out,
    output logic [HW_W-1:0]   o_max_out,
    output logic [HW_W-1:0]   o_mean_out,
    output logic [CNT_W-1:0]  o_cnt_out
);

    localparam int                TO_W     = 16;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << LOG2_S) - 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic             w_init, w_accept, w_timeout;
    logic             r_busy, r_done, r_err;
    logic [SUM_W-1:0] r_sum;
    logic [HW_W-1:0]  r_min, r_max;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= S_IDLE;
        else if (i_en)
            r_state <= w_state_nxt;
    end

    // A start from IDLE or DONE only arms the block; the sample on that edge is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_ACQ;
                    w_init      = 1'b1;
                end
            end
            S_ACQ: begin
                if (i_val_in) begin
                    w_accept = 1'b1;
                    if (r_cnt == LAST_CNT)
                        w_state_nxt = S_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_DONE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_sum    <= '0;
            r_min    <= '1;
            r_max    <= '0;
            r_cnt    <= '0;
            r_to_cnt <= '0;
        end else if (i_en) begin
            r_busy <= (w_state_nxt == S_ACQ);
            r_done <= (w_state_nxt == S_DONE);
            if (w_init) begin
                r_err    <= 1'b0;
                r_sum    <= '0;
                r_min    <= '1;
                r_max    <= '0;
                r_cnt    <= '0;
                r_to_cnt <= '0;
            end else if (w_accept) begin
                r_sum    <= r_sum + SUM_W'(i_hw_in);
                r_cnt    <= r_cnt + CNT_W'(1);
                r_to_cnt <= '0;
                if (i_hw_in < r_min)
                    r_min <= i_hw_in;
                if (i_hw_in > r_max)
                    r_max <= i_hw_in;
            end else if (r_state == S_ACQ) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
                if (w_timeout)
                    r_err <= 1'b1;
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_sum_out  = r_sum;
    assign o_min_out  = r_min;
    assign o_max_out  = r_max;
    assign o_cnt_out  = r_cnt;
    // Upper HW_W bits of the sum are exactly the truncated mean.
    assign o_mean_out = r_sum[SUM_W-1:LOG2_S];

endmodule

// File: tb/tb_tdc_meas_accum.sv
// Bench for tdc_meas_accum: three parameterisations share one stimulus stream
// and are checked every cycle against a sample-list reference model.
module tb_tdc_meas_accum;

    localparam int HW     = 7;
    localparam int NI     = 3;
    localparam int LG [3] = '{4, 4, 0};
    localparam int TOC[3] = '{255, 8, 255};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, start, val;
    logic [HW-1:0] hw;

    logic        busy_o [NI];
    logic        done_o [NI];
    logic        err_o  [NI];
    logic [15:0] sum_o  [NI];
    logic [15:0] cnt_o  [NI];
    logic [15:0] min_o  [NI];
    logic [15:0] max_o  [NI];
    logic [15:0] mean_o [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = LG[g];
        logic [HW+L-1:0] w_sum;
        logic [L:0]      w_cnt;
        logic [HW-1:0]   w_min, w_max, w_mean;
        logic            w_busy, w_done, w_err;
        tdc_meas_accum #(.HW_W(HW), .LOG2_S(L), .TO_CYC(TOC[g])) u_dut (
            .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(start),
            .i_hw_in(hw), .i_val_in(val),
            .o_busy(w_busy), .o_done(w_done), .o_err(w_err),
            .o_sum_out(w_sum), .o_min_out(w_min), .o_max_out(w_max),
            .o_mean_out(w_mean), .o_cnt_out(w_cnt)
        );
        assign busy_o[g] = w_busy;
        assign done_o[g] = w_done;
        assign err_o[g]  = w_err;
        assign sum_o[g]  = 16'(w_sum);
        assign cnt_o[g]  = 16'(w_cnt);
        assign min_o[g]  = 16'(w_min);
        assign max_o[g]  = 16'(w_max);
        assign mean_o[g] = 16'(w_mean);
    end

    // Reference: mode 0=idle 1=acquiring 2=finished; results derived from the sample list.
    int mode [NI];
    int smp  [NI][256];
    int ns   [NI];
    int gap  [NI];
    int merr [NI];

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, g, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                mode[g] = 0; ns[g] = 0; gap[g] = 0; merr[g] = 0;
            end else if (en) begin
                if (mode[g] != 1) begin
                    if (start) begin
                        mode[g] = 1; ns[g] = 0; gap[g] = 0; merr[g] = 0;
                    end
                end else if (val) begin
                    smp[g][ns[g]] = int'(hw);
                    ns[g]++;
                    gap[g] = 0;
                    if (ns[g] == (1 << LG[g])) mode[g] = 2;
                end else begin
                    gap[g]++;
                    if (gap[g] == TOC[g]) begin
                        mode[g] = 2; merr[g] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < NI; g++) begin
            int s, mn, mx;
            s = 0; mn = (1 << HW) - 1; mx = 0;
            for (int k = 0; k < ns[g]; k++) begin
                s += smp[g][k];
                if (smp[g][k] < mn) mn = smp[g][k];
                if (smp[g][k] > mx) mx = smp[g][k];
            end
            chk("busy", g, 32'(busy_o[g]), 32'(mode[g] == 1));
            chk("done", g, 32'(done_o[g]), 32'(mode[g] == 2));
            chk("err",  g, 32'(err_o[g]),  32'(merr[g]));
            chk("sum",  g, 32'(sum_o[g]),  32'(s));
            chk("min",  g, 32'(min_o[g]),  32'(mn));
            chk("max",  g, 32'(max_o[g]),  32'(mx));
            chk("cnt",  g, 32'(cnt_o[g]),  32'(ns[g]));
            chk("mean", g, 32'(mean_o[g]), 32'(s >> LG[g]));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic e, input logic s, input logic v, input int h);
        rst = r; en = e; start = s; val = v; hw = HW'(h);
    endtask

    task automatic do_rst();
        drive(1, 1, 0, 0, 0);
        step();
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            mode[g] = 0; ns[g] = 0; gap[g] = 0; merr[g] = 0;
        end

        // Reset with start held high: start must be ignored.
        drive(1, 1, 1, 1, 33);
        step();
        step();
        chk("rst_sum", 0, 32'(sum_o[0]), 0);
        chk("rst_min", 0, 32'(min_o[0]), 127);
        chk("rst_busy", 0, 32'(busy_o[0]), 0);

        // Sixteen consecutive samples 0..15.
        drive(0, 1, 1, 0, 0);
        step();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 1, i);
            step();
            if (i == 14) chk("d31_early", 0, 32'(done_o[0]), 0);
        end
        chk("d31_done", 0, 32'(done_o[0]), 1);
        chk("d31_sum",  0, 32'(sum_o[0]),  120);
        chk("d31_min",  0, 32'(min_o[0]),  0);
        chk("d31_max",  0, 32'(max_o[0]),  15);
        chk("d31_mean", 0, 32'(mean_o[0]), 7);
        chk("d31_cnt",  0, 32'(cnt_o[0]),  16);
        chk("d31_err",  0, 32'(err_o[0]),  0);

        // Timeout after three samples on the TO_CYC=8 instance.
        do_rst();
        drive(0, 1, 1, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 10);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 0, 99);
            step();
            if (i == 6) chk("d32_early", 1, 32'(done_o[1]), 0);
        end
        chk("d32_done", 1, 32'(done_o[1]), 1);
        chk("d32_err",  1, 32'(err_o[1]),  1);
        chk("d32_cnt",  1, 32'(cnt_o[1]),  3);
        chk("d32_sum",  1, 32'(sum_o[1]),  30);
        chk("d32_min",  1, 32'(min_o[1]),  10);
        chk("d32_max",  1, 32'(max_o[1]),  10);

        // Reset in the middle of acquisition, then a clean measurement.
        do_rst();
        drive(0, 1, 1, 0, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 1, 20 + i);
            step();
        end
        drive(1, 0, 1, 1, 3);
        step();
        chk("d34_busy", 0, 32'(busy_o[0]), 0);
        chk("d34_sum",  0, 32'(sum_o[0]),  0);
        chk("d34_min",  0, 32'(min_o[0]),  127);
        drive(0, 1, 1, 0, 0);
        step();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 1, int'($urandom_range(0, 127)));
            step();
        end
        chk("d34_done", 0, 32'(done_o[0]), 1);

        // Gapped samples of 64 with a five-cycle enable drop mid-stream.
        do_rst();
        drive(0, 1, 1, 0, 0);
        step();
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                for (int k = 0; k < 5; k++) begin
                    drive(0, 0, 1, 1, 1);
                    step();
                    chk("d33_hold_sum", 0, 32'(sum_o[0]), 512);
                    chk("d33_hold_cnt", 0, 32'(cnt_o[0]), 8);
                end
            end
            drive(0, 1, 0, 1, 64);
            step();
            if (i < 15) begin
                drive(0, 1, 0, 0, 5);
                step();
                step();
            end
        end
        chk("d33_sum",  0, 32'(sum_o[0]),  1024);
        chk("d33_mean", 0, 32'(mean_o[0]), 64);
        chk("d33_err",  1, 32'(err_o[1]),  0);
        chk("d33_done", 1, 32'(done_o[1]), 1);

        // Single-sample instance: start-edge sample dropped, relaunch from DONE.
        do_rst();
        drive(0, 1, 1, 1, 5);
        step();
        drive(0, 1, 0, 1, 127);
        step();
        chk("d35_done", 2, 32'(done_o[2]), 1);
        chk("d35_sum",  2, 32'(sum_o[2]),  127);
        chk("d35_mean", 2, 32'(mean_o[2]), 127);
        chk("d35_cnt",  2, 32'(cnt_o[2]),  1);
        drive(0, 1, 1, 1, 9);
        step();
        chk("d35_relaunch", 2, 32'(busy_o[2]), 1);
        chk("d35_relcnt",   2, 32'(cnt_o[2]),  0);
        drive(0, 1, 0, 1, 3);
        step();
        chk("d35_sum2", 2, 32'(sum_o[2]), 3);

        // Random traffic with alternating dense and sparse valid phases.
        for (int c = 0; c < 800; c++) begin
            int vp;
            vp = ((c / 60) % 2 == 0) ? 70 : 12;
            drive(logic'($urandom_range(0, 99) < 2), logic'($urandom_range(0, 99) < 90),
                  logic'($urandom_range(0, 99) < 10), logic'($urandom_range(0, 99) < vp),
                  int'($urandom_range(0, 127)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/tdc_meas_accum.md
TDC_MEAS_ACCUM -- requirements
Module: tdc_meas_accum

Interface
REQ-001 SHALL have parameter HW_W, default 7: width of the Hamming-weight sample (log2(N)+1 for an N-stage delay line).
REQ-002 SHALL have parameter LOG2_S, default 4: samples per measurement = 2^LOG2_S; legal range 0..8.
REQ-003 SHALL have parameter TO_CYC, default 255: consecutive no-valid cycles that abort a measurement; legal range 1..65535.
REQ-004 SHALL have derived widths SUM_W = HW_W+LOG2_S and CNT_W = LOG2_S+1.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  block enable; 0 freezes all state and outputs.
REQ-008 start  in  1  measurement request, sampled per cycle.
REQ-009 hw_in  in  HW_W  TDC Hamming-weight sample.
REQ-010 val_in  in  1  hw_in qualifier, one sample per high cycle.
REQ-011 busy  out  1  high in ACQ.
REQ-012 done  out  1  high in DONE.
REQ-013 err  out  1  last measurement ended by timeout.
REQ-014 sum_out  out  SUM_W  sum of accepted samples.
REQ-015 min_out / max_out  out  HW_W each  extremes of accepted samples.
REQ-016 mean_out  out  HW_W  sum_out >> LOG2_S, truncating.
REQ-017 cnt_out  out  CNT_W  number of accepted samples.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACQ, DONE; state register and all outputs registered.
REQ-019 IDLE: start=1 -> ACQ next cycle; sum=0, cnt=0, min=all-ones, max=0, err=0, timeout counter=0 loaded in the same edge.
REQ-020 ACQ: each cycle with val_in=1, sum += hw_in, min = min(min, hw_in), max = max(max, hw_in), cnt += 1, timeout counter cleared; all visible one cycle after the sample.
REQ-021 ACQ: the sample bringing cnt to 2^LOG2_S SHALL cause transition to DONE on the same edge (done high the cycle after the last sample); err=0.
REQ-022 ACQ: each cycle with val_in=0 increments the timeout counter; on reaching TO_CYC -> DONE with err=1; partial sum/min/max/cnt retained.
REQ-023 DONE: outputs held; start=1 -> ACQ with the REQ-019 initialisation (back-to-back measurements, no IDLE visit).
REQ-024 start in ACQ SHALL be ignored; val_in in IDLE or DONE SHALL be ignored.
REQ-025 start and val_in high on the IDLE->ACQ edge: the sample SHALL NOT be accepted; first acceptable sample is the following cycle.
REQ-026 sum SHALL NOT overflow: SUM_W holds 2^LOG2_S * (2^HW_W - 1) exactly.
REQ-027 en=0 SHALL hold state, counters, timeout counter and outputs; samples and start presented while en=0 are dropped.
REQ-028 mean_out is combinational from registered sum_out; valid only when done=1 and err=0.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE and busy=done=err=0, sum_out=cnt_out=0, min_out=all-ones, max_out=0, regardless of en or state (including mid-ACQ).
REQ-030 start sampled with rst=1 SHALL be ignored; measurement needs start on a cycle with rst=0.

Verification
REQ-031 Defaults; start, then 16 consecutive valid samples hw=0..15 -> done high 1 cycle after 16th sample, sum_out=120, min_out=0, max_out=15, mean_out=7, cnt_out=16, err=0.
REQ-032 TO_CYC=8; start, 3 valid samples hw=10, then val_in=0 -> done after 8 idle cycles, err=1, cnt_out=3, sum_out=30, min=max=10.
REQ-033 Gapped samples (val_in every third cycle, 16 samples of hw=64), en low 5 cycles mid-stream -> sum_out=1024, mean_out=64, no timeout, frozen values held during en=0.
REQ-034 rst pulse after 5 samples -> next cycle IDLE, sum_out=0, min_out=127; new start yields clean measurement of only post-reset samples.
REQ-035 LOG2_S=0, start+val_in same cycle then hw=127 next cycle -> first sample dropped, done with sum_out=127, mean_out=127, cnt_out=1; start in DONE relaunches ACQ directly.
